// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector with two internal line buffers.
// Ports: clk, rst_n (sync, active low); din/din_vld/din_sop/din_eop in;
//   thresh (11b) on |Gx|+|Gy|; dout (FF=edge) with dout_vld/sop/eop out.
module sobel_edge #(
    parameter int IMG_W = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic [10:0] thresh,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    logic [CW-1:0] col;
    logic [1:0]    row;
    logic [CW-1:0] pcol;
    logic [1:0]    prow;
    logic          acc;

    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];
    logic [7:0] tap0;
    logic [7:0] tap1;

    logic [7:0] win [3][3];
    logic       v1;
    logic       bdr1;
    logic       sop1;
    logic       eop1;

    logic [9:0]        sum_r;
    logic [9:0]        sum_l;
    logic [9:0]        sum_b;
    logic [9:0]        sum_t;
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic signed [10:0] ngx;
    logic signed [10:0] ngy;
    logic [9:0]        ax;
    logic [9:0]        ay;

    logic       v2;
    logic [9:0] ax2;
    logic [9:0] ay2;
    logic       bdr2;
    logic       sop2;
    logic       eop2;
    logic [10:0] mag;

    // A sop pixel is always taken as column 0, row 0 of a new frame.
    always_comb begin
        pcol = din_sop ? '0 : col;
        prow = din_sop ? 2'd0 : row;
        acc  = din_vld & rst_n;
        tap0 = lb0[pcol];
        tap1 = lb1[pcol];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= 2'd0;
        end else if (din_vld) begin
            if (pcol == COL_LAST) begin
                col <= '0;
                row <= (prow == 2'd2) ? prow : prow + 2'd1;
            end else begin
                col <= pcol + COL_ONE;
                row <= prow;
            end
        end
    end

    // Read-before-write: lb0 receives the row that lb1 held at this column.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[pcol] <= din;
            lb0[pcol] <= lb1[pcol];
        end
    end

    // Stage 1: window shift, newest column enters at index 2.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= tap0;
            win[1][2] <= tap1;
            win[2][2] <= din;
            bdr1      <= (prow < 2'd2) | (pcol < COL_TWO);
            sop1      <= din_sop;
            eop1      <= din_eop;
        end
    end

    always_comb begin
        sum_r = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
        sum_l = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
        sum_b = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
        sum_t = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};
        gx    = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
        gy    = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
        ngx   = -gx;
        ngy   = -gy;
        ax    = gx[10] ? ngx[9:0] : gx[9:0];
        ay    = gy[10] ? ngy[9:0] : gy[9:0];
    end

    // Stage 2 data registers.
    always_ff @(posedge clk) begin
        if (v1) begin
            ax2  <= ax;
            ay2  <= ay;
            bdr2 <= bdr1;
            sop2 <= sop1;
            eop2 <= eop1;
        end
    end

    always_comb mag = {1'b0, ax2} + {1'b0, ay2};

    // Pipeline valids and stage 3 output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            dout     <= 8'h00;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            v1       <= din_vld;
            v2       <= v1;
            dout_vld <= v2;
            dout_sop <= v2 & sop2;
            dout_eop <= v2 & eop2;
            if (v2) begin
                dout <= (!bdr2 && (mag > thresh)) ? 8'hFF : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: frame-array reference model,
// decoupled driver and negedge monitor.
module tb_sobel_edge;

    localparam int W    = 8;
    localparam int MAXR = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [10:0] thresh = 11'd0;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;

    sobel_edge #(.IMG_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .thresh   (thresh),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        int         t;
    } exp_t;

    exp_t sbq[$];
    exp_t mx;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   chk_rst = 1'b0;
    logic [7:0] last_d = 8'h00;

    int img [MAXR][W];
    int mr = 0;
    int mc = 0;

    always @(posedge clk) cyc++;

    // Sobel of the 3x3 neighbourhood whose bottom-right corner is (r,c).
    function automatic logic [7:0] ref_pix(int r, int c);
        int wt [3] = '{1, 2, 1};
        int gx = 0;
        int gy = 0;
        int mag;
        for (int i = 0; i < 3; i++) begin
            gx += wt[i] * (img[r-2+i][c] - img[r-2+i][c-2]);
            gy += wt[i] * (img[r][c-2+i] - img[r-2][c-2+i]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > int'(thresh)) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] pixval(int kind, int c);
        case (kind)
            0: return 8'h80;
            1: return (c < 4) ? 8'h00 : 8'hFF;
            2: return (c < 4) ? 8'h00 : 8'd100;
            3: return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(100, 130));
        endcase
    endfunction

    task automatic send(input logic [7:0] p, input bit s, input bit e);
        exp_t x;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = int'(p);
        x.d = (mr < 2 || mc < 2) ? 8'h00 : ref_pix(mr, mc);
        x.s = s;
        x.e = e;
        x.t = cyc;
        sbq.push_back(x);
        din     = p;
        din_vld = 1'b1;
        din_sop = s;
        din_eop = e;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        mc++;
        if (mc == W) begin
            mc = 0;
            if (mr < MAXR - 1) mr++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int kind, input int rows, input int gap);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                send(pixval(kind, c), (r == 0 && c == 0),
                     (r == rows - 1 && c == W - 1));
                if (gap == 1) idle(1);
                else if (gap == 2 && $urandom_range(0, 3) == 0)
                    idle($urandom_range(1, 3));
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d outputs pending, required 0", sbq.size());
            sbq.delete();
        end
        idle(2);
    endtask

    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        din_vld = 1'b1;
        din     = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        sbq.delete();
        chk_rst = 1'b1;
        mon_en  = 1'b1;
        idle(n - 1);
        rst_n   = 1'b1;
        chk_rst = 1'b0;
        din_vld = 1'b0;
        mr = 0;
        mc = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_rst) begin
                n_vec++;
                if (dout_vld !== 1'b0 || dout !== 8'h00) begin
                    n_bad++;
                    $display("FAIL reset: dout_vld=%0b dout=%02h, required 0/00",
                             dout_vld, dout);
                end
                last_d = 8'h00;
            end else if (dout_vld === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious: dout_vld=1 at cycle %0d, required 0", cyc);
                end else begin
                    mx = sbq.pop_front();
                    n_vec++;
                    if ({dout, dout_sop, dout_eop} !== {mx.d, mx.s, mx.e}) begin
                        n_bad++;
                        $display("FAIL pixel: got %02h sop=%0b eop=%0b, required %02h sop=%0b eop=%0b",
                                 dout, dout_sop, dout_eop, mx.d, mx.s, mx.e);
                    end
                    n_vec++;
                    if (cyc - mx.t != 3) begin
                        n_bad++;
                        $display("FAIL latency: got %0d clks, required 3", cyc - mx.t);
                    end
                end
                last_d = dout;
            end else begin
                n_vec++;
                if (dout !== last_d || dout_sop !== 1'b0 || dout_eop !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hold: dout=%02h sop=%0b eop=%0b, required %02h 0 0",
                             dout, dout_sop, dout_eop, last_d);
                end
            end
        end
    end

    initial begin
        do_reset(4);

        thresh = 11'd0;
        send_frame(0, 4, 0);
        drain();

        thresh = 11'd100;
        send_frame(1, 4, 0);
        drain();

        thresh = 11'd399;
        send_frame(2, 3, 0);
        drain();
        thresh = 11'd400;
        send_frame(2, 3, 0);
        drain();

        thresh = 11'd60;
        send_frame(4, 4, 1);
        drain();
        send_frame(4, 4, 0);
        drain();

        thresh = 11'd50;
        for (int i = 0; i < 13; i++)
            send(pixval(3, 0), (i == 0), 1'b0);
        send_frame(3, 4, 0);
        drain();

        for (int i = 0; i < 11; i++)
            send(pixval(3, 0), (i == 0), 1'b0);
        do_reset(3);
        for (int i = 0; i < 10; i++)
            send(pixval(3, 0), 1'b0, 1'b0);
        send_frame(3, 3, 2);
        drain();

        repeat (6) begin
            thresh = 11'($urandom_range(0, 800));
            send_frame($urandom_range(3, 4), $urandom_range(3, 7),
                       $urandom_range(0, 2));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
